// File: rtl/bpred_check.sv
// Branch-prediction checker: in-order FIFO of predictions resolved at WB, with flush/redirect and fetch-stall recovery.
// Optional statistics counters are enabled by defining BPRED_STATS_EN.
module bpred_check #(
  parameter int DEPTH   = 4,
  parameter int RECOVER = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pred_valid,
  input  logic [15:0] pred_pc,
  input  logic [15:0] pred_target,
  output logic        pred_ready,
  input  logic        res_valid,
  input  logic [15:0] res_pc,
  input  logic [15:0] res_target,
  output logic        flush,
  output logic [15:0] redirect_pc,
  output logic        stall_if,
  output logic        upd_valid,
  output logic [15:0] upd_pc,
  output logic [15:0] upd_target,
  output logic        desync,
  output logic [15:0] mispred_cnt,
  output logic [15:0] resolved_cnt
);

  localparam int           AW          = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT    = DEPTH[AW:0];
  localparam logic [2:0]   RECOVER_CNT = RECOVER[2:0];

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FLUSH = 2'd1, ST_DRAIN = 2'd2} state_t;

  state_t         r_state, w_state_nxt;
  logic [2:0]     r_drain_cnt, w_drain_cnt_nxt;
  logic [15:0]    r_q_pc  [DEPTH];
  logic [15:0]    r_q_tgt [DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [AW:0]    r_count;
  logic           r_flush, r_upd_valid, r_desync;
  logic [15:0]    r_redirect_pc, r_upd_pc, r_upd_target;
  logic           w_idle, w_full, w_empty, w_pop, w_push, w_pc_bad, w_mispred;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == {(AW+1){1'b0}});
  assign w_pop      = w_idle && res_valid && !w_empty;
  assign w_pc_bad   = (r_q_pc[r_rd_ptr] != res_pc);
  assign w_mispred  = w_pop && (w_pc_bad || (r_q_tgt[r_rd_ptr] != res_target));
  assign pred_ready = w_idle && (!w_full || res_valid);
  // A push racing a mispredicting pop is dropped; the queue is cleared in FLUSH anyway.
  assign w_push     = pred_valid && pred_ready && !w_mispred;

  assign flush       = r_flush;
  assign redirect_pc = r_redirect_pc;
  assign upd_valid   = r_upd_valid;
  assign upd_pc      = r_upd_pc;
  assign upd_target  = r_upd_target;
  assign desync      = r_desync;
  assign stall_if    = !w_idle;

  // Recovery FSM state and drain counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // Next-state logic: IDLE -> FLUSH on mispredict, one FLUSH cycle, RECOVER DRAIN cycles.
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_mispred) w_state_nxt = ST_FLUSH;
        else           w_state_nxt = ST_IDLE;
      end
      ST_FLUSH: begin
        w_state_nxt     = ST_DRAIN;
        w_drain_cnt_nxt = RECOVER_CNT;
      end
      ST_DRAIN: begin
        if (r_drain_cnt <= 3'd1) begin
          w_state_nxt     = ST_IDLE;
          w_drain_cnt_nxt = 3'd0;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_drain_cnt_nxt = 3'd0;
      end
    endcase
  end

  // Queue pointers and occupancy; FLUSH empties the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (r_state == ST_FLUSH) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue payload storage; validity is tracked by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]  <= pred_pc;
      r_q_tgt[r_wr_ptr] <= pred_target;
    end
  end

  // Registered flush/BTB-update pulse and sticky desync flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flush       <= 1'b0;
      r_upd_valid   <= 1'b0;
      r_redirect_pc <= 16'h0000;
      r_upd_pc      <= 16'h0000;
      r_upd_target  <= 16'h0000;
      r_desync      <= 1'b0;
    end else begin
      r_flush     <= w_mispred;
      r_upd_valid <= w_mispred;
      if (w_mispred) begin
        r_redirect_pc <= res_target;
        r_upd_pc      <= res_pc;
        r_upd_target  <= res_target;
      end
      if (w_idle && res_valid && (w_empty || w_pc_bad)) r_desync <= 1'b1;
    end
  end

`ifdef BPRED_STATS_EN
  logic [15:0] r_mispred_cnt, r_resolved_cnt;

  // Saturating resolution/mispredict statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mispred_cnt  <= 16'h0000;
      r_resolved_cnt <= 16'h0000;
    end else begin
      if (w_pop && (r_resolved_cnt != 16'hFFFF))    r_resolved_cnt <= r_resolved_cnt + 16'h0001;
      if (w_mispred && (r_mispred_cnt != 16'hFFFF)) r_mispred_cnt  <= r_mispred_cnt + 16'h0001;
    end
  end

  assign mispred_cnt  = r_mispred_cnt;
  assign resolved_cnt = r_resolved_cnt;
`else
  assign mispred_cnt  = 16'h0000;
  assign resolved_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_bpred_check.sv
// Scoreboard bench for bpred_check: a queue-based reference model predicts flush/update events,
// a monitor process pops and compares them; status outputs are checked every cycle.
module tb_bpred_check;
  localparam int DEPTH   = 4;
  localparam int RECOVER = 2;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        pred_valid = 1'b0, res_valid = 1'b0;
  logic [15:0] pred_pc = 16'h0, pred_target = 16'h0, res_pc = 16'h0, res_target = 16'h0;
  logic        pred_ready, flush, stall_if, upd_valid, desync;
  logic [15:0] redirect_pc, upd_pc, upd_target, mispred_cnt, resolved_cnt;

  bpred_check #(.DEPTH(DEPTH), .RECOVER(RECOVER)) dut (
    .clk(clk), .reset_n(reset_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_pc(res_pc), .res_target(res_target),
    .flush(flush), .redirect_pc(redirect_pc), .stall_if(stall_if),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .desync(desync), .mispred_cnt(mispred_cnt), .resolved_cnt(resolved_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] pc; logic [15:0] tgt; } ent_t;
  typedef struct { logic [15:0] redir; logic [15:0] upc; logic [15:0] utgt; } exp_t;

  ent_t mq[$];          // model of in-flight predictions
  exp_t eq[$];          // expected flush/update events
  int   stall_left = 0; // remaining recovery cycles (FLUSH + DRAIN)
  bit   m_desync = 1'b0;
  int   m_res = 0, m_mis = 0;
  int   n_tests = 0, n_fail = 0;
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return (stall_left == 0) && ((mq.size() < DEPTH) || res_valid);
  endfunction

  // Apply the specification rules for one rising edge with the currently driven inputs.
  task automatic model_step();
    bit   rdy, mis;
    ent_t h, n;
    exp_t e;
    if (stall_left > 0) begin
      stall_left--;
    end else begin
      rdy = model_ready();
      mis = 1'b0;
      if (res_valid) begin
        if (mq.size() == 0) m_desync = 1'b1;
        else begin
          h = mq.pop_front();
          if (m_res < 65535) m_res++;
          if (h.pc != res_pc) begin m_desync = 1'b1; mis = 1'b1; end
          if (h.tgt != res_target) mis = 1'b1;
        end
      end
      if (mis) begin
        if (m_mis < 65535) m_mis++;
        e.redir = res_target; e.upc = res_pc; e.utgt = res_target;
        eq.push_back(e);
        mq.delete();
        stall_left = RECOVER + 1;
      end else if (pred_valid && rdy) begin
        n.pc = pred_pc; n.tgt = pred_target;
        mq.push_back(n);
      end
    end
  endtask

  task automatic cycle(input bit pv, input logic [15:0] pp, input logic [15:0] pt,
                       input bit rv, input logic [15:0] rp, input logic [15:0] rt);
    @(negedge clk);
    chk("stall_if", stall_if, stall_left > 0);
    chk("desync", desync, m_desync);
`ifdef BPRED_STATS_EN
    chk("resolved_cnt", resolved_cnt, m_res);
    chk("mispred_cnt", mispred_cnt, m_mis);
`else
    chk("resolved_cnt", resolved_cnt, 32'd0);
    chk("mispred_cnt", mispred_cnt, 32'd0);
`endif
    pred_valid = pv; pred_pc = pp; pred_target = pt;
    res_valid = rv; res_pc = rp; res_target = rt;
    #1;
    chk("pred_ready", pred_ready, model_ready());
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flush"}, flush, 32'd0);
    chk({tag, "_upd_valid"}, upd_valid, 32'd0);
    chk({tag, "_stall_if"}, stall_if, 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    chk({tag, "_upd_pc"}, upd_pc, 32'd0);
    chk({tag, "_upd_target"}, upd_target, 32'd0);
    chk({tag, "_desync"}, desync, 32'd0);
    chk({tag, "_mispred_cnt"}, mispred_cnt, 32'd0);
    chk({tag, "_resolved_cnt"}, resolved_cnt, 32'd0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    pred_valid = 1'b0; res_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    chk("reset_pred_ready", pred_ready, 32'd1);
    mq.delete(); eq.delete();
    stall_left = 0; m_desync = 1'b0; m_res = 0; m_mis = 0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  // Monitor: every flush/update pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (reset_n && (flush || upd_valid)) begin
      if (eq.size() == 0) begin
        chk("unexpected_flush_upd", {30'd0, flush, upd_valid}, 32'd0);
      end else begin
        mon_e = eq.pop_front();
        chk("flush", flush, 32'd1);
        chk("upd_valid", upd_valid, 32'd1);
        chk("redirect_pc", redirect_pc, mon_e.redir);
        chk("upd_pc", upd_pc, mon_e.upc);
        chk("upd_target", upd_target, mon_e.utgt);
      end
    end
  end

  initial begin
    logic [15:0] pc, pt, rp, rt;
    bit pv, rv;
    #3;
    chk_all_zero("reset_state");
    #10 reset_n = 1'b1;

    // Correct prediction: pop only.
    cycle(1'b1, 16'h3000, 16'h3002, 1'b0, 16'h0, 16'h0);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'h3000, 16'h3002);
    idle(3);

    // Mispredict: flush/redirect then RECOVER+1 stalled cycles with pushes ignored.
    cycle(1'b1, 16'h3010, 16'h3012, 1'b0, 16'h0, 16'h0);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'h3010, 16'h3040);
    for (int i = 0; i < RECOVER + 1; i++) cycle(1'b1, 16'h5000, 16'h5002, 1'b0, 16'h0, 16'h0);
    idle(1);

    // Full queue: simultaneous push/pop accepted, lone push refused.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 16'h3100 + 16'(2*i), 16'h3102 + 16'(2*i), 1'b0, 16'h0, 16'h0);
    cycle(1'b1, 16'h3200, 16'h3202, 1'b1, 16'h3100, 16'h3102);
    cycle(1'b1, 16'h3300, 16'h3302, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < DEPTH && mq.size() > 0; i++)
      cycle(1'b0, 16'h0, 16'h0, 1'b1, mq[0].pc, mq[0].tgt);
    idle(2);

    // Resolution on empty queue: sticky desync until reset.
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'h1234, 16'h1236);
    idle(4);
    do_reset();
    idle(1);

    // Reset during DRAIN aborts recovery.
    cycle(1'b1, 16'h3400, 16'h3402, 1'b0, 16'h0, 16'h0);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'h3400, 16'h3480);
    idle(2);
    do_reset();
    idle(2);

    // Ten resolutions, three of them mispredicted.
    for (int i = 0; i < 10; i++) begin
      pc = 16'h4000 + 16'(4*i);
      cycle(1'b1, pc, pc + 16'h2, 1'b0, 16'h0, 16'h0);
      cycle(1'b0, 16'h0, 16'h0, 1'b1, pc, (i == 0 || i == 3 || i == 6) ? 16'h7000 : pc + 16'h2);
      idle(RECOVER + 2);
    end
`ifdef BPRED_STATS_EN
    chk("stats_resolved_10", resolved_cnt, 32'd10);
    chk("stats_mispred_3", mispred_cnt, 32'd3);
`else
    chk("stats_resolved_off", resolved_cnt, 32'd0);
    chk("stats_mispred_off", mispred_cnt, 32'd0);
`endif
    do_reset();

    // Randomized traffic against the reference model.
    for (int k = 0; k < 1500; k++) begin
      if (k == 750) do_reset();
      pv = ($urandom_range(0, 1) == 1);
      pc = 16'($urandom) & 16'hFFFE;
      pt = ($urandom_range(0, 1) == 1) ? pc + 16'h2 : (16'($urandom) & 16'hFFFE);
      rv = ($urandom_range(0, 2) == 0);
      if (mq.size() > 0 && $urandom_range(0, 7) != 0) begin
        rp = mq[0].pc;
        rt = ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'hFFFE) : mq[0].tgt;
      end else begin
        rp = 16'($urandom) & 16'hFFFE;
        rt = 16'($urandom) & 16'hFFFE;
      end
      cycle(pv, pc, pt, rv, rp, rt);
    end
    idle(RECOVER + 3);
    chk("expected_events_drained", eq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
